// File: rtl/barrel_shift_pkg.sv
// Shared constants and types for the barrel shifter.
// The rotate feature of barrel_shift is enabled by defining BARREL_SHIFT_ROTATE_EN.
package barrel_shift_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  // One cascade stage per shift-amount bit.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One conditional shift-by-DIST stage of the barrel shifter cascade.
// With BARREL_SHIFT_ROTATE_EN defined, the stage can also rotate left.
module barrel_shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en,
`ifdef BARREL_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] data_o
);

  // Shift (or rotate) by DIST when enabled, otherwise pass through.
  always_comb begin
    data_o = data_i;
    if (en) begin
`ifdef BARREL_SHIFT_ROTATE_EN
      if (rotate) begin
        data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
      end else begin
        data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
      end
`else
      data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
`endif
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/barrel_shift.sv
// Registered logical left barrel shifter with one cycle of latency.
// Optional left-rotate mode is enabled by defining BARREL_SHIFT_ROTATE_EN.
module barrel_shift
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int SHAMT_W = shamt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   shift_str,
  input  logic [SHAMT_W-1:0] shift_amnt,
`ifdef BARREL_SHIFT_ROTATE_EN
  input  logic               rotate,
`endif
  output logic [WIDTH-1:0]   shifted_str,
  output logic               out_valid
);

  logic [WIDTH-1:0] stage_data [SHAMT_W+1];
  logic [WIDTH-1:0] shifted_str_d, shifted_str_q;
  logic             out_valid_d, out_valid_q;

  assign stage_data[0] = shift_str;

  // Stage k moves the word by 2^k when shift_amnt[k] is set.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_stage (
      .data_i (stage_data[k]),
      .en     (shift_amnt[k]),
`ifdef BARREL_SHIFT_ROTATE_EN
      .rotate (rotate),
`endif
      .data_o (stage_data[k+1])
    );
  end

  // Capture a new result on in_valid, otherwise hold the last one.
  always_comb begin
    shifted_str_d = shifted_str_q;
    out_valid_d   = 1'b0;
    if (in_valid) begin
      shifted_str_d = stage_data[SHAMT_W];
      out_valid_d   = 1'b1;
    end else begin
      shifted_str_d = shifted_str_q;
      out_valid_d   = 1'b0;
    end
  end

  // Output register; reset discards any sample presented alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shifted_str_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      shifted_str_q <= shifted_str_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign shifted_str = shifted_str_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_barrel_shift.sv
// Self-checking bench for barrel_shift: directed vectors plus a randomized sweep
// against a wide-arithmetic reference model. Honors BARREL_SHIFT_ROTATE_EN.
module tb_barrel_shift;
  import barrel_shift_pkg::*;

  localparam int W  = WIDTH_DEFAULT;
  localparam int SW = shamt_w(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  word_t         shift_str;
  logic [SW-1:0] shift_amnt;
  word_t         shifted_str;
  logic          out_valid;
`ifdef BARREL_SHIFT_ROTATE_EN
  logic          rotate;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  word_t exp_str;
  logic  exp_valid;

  always #5 clk = ~clk;

  barrel_shift #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .shift_str   (shift_str),
    .shift_amnt  (shift_amnt),
`ifdef BARREL_SHIFT_ROTATE_EN
    .rotate      (rotate),
`endif
    .shifted_str (shifted_str),
    .out_valid   (out_valid)
  );

  // Reference: shift into a double-width word; the upper half is what left the MSB.
  function automatic word_t ref_model(input word_t op, input int amt, input bit rot);
    logic [2*W-1:0] wide;
    wide = {{W{1'b0}}, op} << amt;
    if (rot) return wide[W-1:0] | wide[2*W-1:W];
    else     return wide[W-1:0];
  endfunction

  // Drive one cycle, advance the model across the edge, then settle past it.
  task automatic drive(input logic r, input logic v, input word_t d, input int a, input bit rot);
    rst        = r;
    in_valid   = v;
    shift_str  = d;
    shift_amnt = SW'(a);
`ifdef BARREL_SHIFT_ROTATE_EN
    rotate     = rot;
`endif
    @(posedge clk);
    if (r) begin
      exp_str   = '0;
      exp_valid = 1'b0;
    end else if (v) begin
`ifdef BARREL_SHIFT_ROTATE_EN
      exp_str   = ref_model(d, a, rot);
`else
      exp_str   = ref_model(d, a, 1'b0);
`endif
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'hD6975971, 4, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got str=%h valid=%b want str=00000000 valid=0", shifted_str, out_valid);
    end
    drive(1'b0, 1'b0, 32'h12345678, 1, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got str=%h valid=%b want str=00000000 valid=0", shifted_str, out_valid);
    end
  endtask

  task automatic test_vectors();
    int    amts [8] = '{4, 2, 3, 5, 10, 0, 31, 31};
    word_t ops  [8] = '{32'hD6975971, 32'hD6975971, 32'hD6975971, 32'hD6975971,
                        32'hD6975971, 32'hD6975971, 32'hD6975971, 32'hFFFFFFFF};
    word_t want [8] = '{32'h69759710, 32'h5A5D65C4, 32'hB4BACB88, 32'hD2EB2E20,
                        32'h5D65C400, 32'hD6975971, 32'h80000000, 32'h80000000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, ops[i], amts[i], 1'b0);
      n_cmp++;
      if (shifted_str !== want[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL vector%0d amt=%0d: got str=%h valid=%b want str=%h valid=1",
                 i, amts[i], shifted_str, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 32'hD6975971, 4, 1'b0);
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 1, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h69759710 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold: got str=%h valid=%b want str=69759710 valid=0", shifted_str, out_valid);
    end
    drive(1'b0, 1'b0, 32'h00000001, 3, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h69759710 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold2: got str=%h valid=%b want str=69759710 valid=0", shifted_str, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 32'hD6975971, 4, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got str=%h valid=%b want str=00000000 valid=0", shifted_str, out_valid);
    end
    drive(1'b0, 1'b1, 32'h00000003, 1, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h00000006 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_after_reset: got str=%h valid=%b want str=00000006 valid=1", shifted_str, out_valid);
    end
  endtask

`ifdef BARREL_SHIFT_ROTATE_EN
  task automatic test_rotate();
    drive(1'b0, 1'b1, 32'hD6975971, 4, 1'b1);
    n_cmp++;
    if (shifted_str !== 32'h6975971D || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rotate4: got str=%h valid=%b want str=6975971D valid=1", shifted_str, out_valid);
    end
    drive(1'b0, 1'b1, 32'hD6975971, 4, 1'b0);
    n_cmp++;
    if (shifted_str !== 32'h69759710 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL shift4_rotsel0: got str=%h valid=%b want str=69759710 valid=1", shifted_str, out_valid);
    end
  endtask
`endif

  task automatic test_back_to_back_random();
    int errs_here = 0;
    for (int i = 0; i < 10000; i++) begin
      logic  v;
      word_t d;
      int    a;
      bit    rot;
      v   = ($urandom_range(0, 15) != 0);
      d   = $urandom;
      a   = $urandom_range(0, W-1);
      rot = 1'($urandom_range(0, 1));
      drive(1'b0, v, d, a, rot);
      n_cmp++;
      if (shifted_str !== exp_str || out_valid !== exp_valid) begin
        n_err++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random%0d op=%h amt=%0d v=%b: got str=%h valid=%b want str=%h valid=%b",
                   i, d, a, v, shifted_str, out_valid, exp_str, exp_valid);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    shift_str  = '0;
    shift_amnt = '0;
`ifdef BARREL_SHIFT_ROTATE_EN
    rotate     = 1'b0;
`endif
    exp_str    = '0;
    exp_valid  = 1'b0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_hold();
    test_reset_midstream();
`ifdef BARREL_SHIFT_ROTATE_EN
    test_rotate();
`endif
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
